tappy_rx: RTL and testbench

Parametrised successor to the tappy keyboard-style serial receiver. Oversamples an asynchronous serial clock/data pair (10–16.7 kHz line clock) on sysclk, which runs at least 4x the maximum line frequency. Deframes start / data / parity / stop bits and presents a completed word with a one-cycle done strobe. Adds over the previous generation:
- configurable word width
- configurable parity mode
- frame timeout
- classified error reporting

---
 rtl/tappy_rx.sv | 161 ++++++++++++++++
 tb/tb_tappy_rx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tappy_rx.sv
// tappy_rx: oversampled serial clock/data receiver with configurable width/parity, frame timeout and classified errors.
// Optional build macro TAPPY_RX_GLITCH_FILTER_EN adds a 3-sample agreement filter on the synchronised line clock.
module tappy_rx #(
  parameter int WIDTH   = 8,
  parameter int PARITY  = 1,
  parameter int TIMEOUT = 32
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             clk,
  input  logic             dat,
  output logic [WIDTH-1:0] word,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_kind,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [7:0]        TMO      = 8'(TIMEOUT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] PAR  = 2'd2;
  localparam logic [1:0] STOP = 2'd3;

  localparam logic [1:0] ERR_PARITY  = 2'd0;
  localparam logic [1:0] ERR_STOP    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic parity_ok(input logic [WIDTH-1:0] d, input logic p);
    if (PARITY == 1)      return (^d) ^ p;
    else if (PARITY == 2) return ~((^d) ^ p);
    else                  return 1'b1;
  endfunction

  logic             clk_p0, clk_p1, dat_p0, dat_p1;
  logic             clk_line, dat_line, clk_prev, vld_p2, tmo_hit;
  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shift;
  logic             par_bit;
  logic [7:0]       tmo_cnt;

  // Stage p0/p1: two-flop synchronisers, preset to the idle-high line level
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= clk;
      clk_p1 <= clk_p0;
      dat_p0 <= dat;
      dat_p1 <= dat_p0;
    end
  end

`ifdef TAPPY_RX_GLITCH_FILTER_EN
  logic clk_p2, clk_p3, dat_p2, dat_p3;

  // Stage p2/p3: clock history for the agreement filter; data delayed to stay aligned
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      clk_p2 <= 1'b1;
      clk_p3 <= 1'b1;
      dat_p2 <= 1'b1;
      dat_p3 <= 1'b1;
    end else begin
      clk_p2 <= clk_p1;
      clk_p3 <= clk_p2;
      dat_p2 <= dat_p1;
      dat_p3 <= dat_p2;
    end
  end

  // clk_prev holds the last filtered level, so disagreement keeps it unchanged
  assign clk_line = (clk_p1 == clk_p2 && clk_p2 == clk_p3) ? clk_p1 : clk_prev;
  assign dat_line = dat_p3;
`else
  assign clk_line = clk_p1;
  assign dat_line = dat_p1;
`endif

  // Edge stage: falling edge marks dat_line as a valid bit sample
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) clk_prev <= 1'b1;
    else        clk_prev <= clk_line;
  end

  assign vld_p2  = clk_prev & ~clk_line;
  assign tmo_hit = (state != IDLE) && (tmo_cnt >= TMO);
  assign busy    = (state != IDLE);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset)                       tmo_cnt <= 8'd0;
    else if (vld_p2 || state == IDLE) tmo_cnt <= 8'd0;
    else                              tmo_cnt <= sat_inc(tmo_cnt);
  end

  // Deframing stage: FSM and registered output strobes
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      word     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_kind <= ERR_PARITY;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (tmo_hit) begin
        // a falling edge coinciding with the timeout is deliberately dropped
        err      <= 1'b1;
        err_kind <= ERR_TIMEOUT;
        state    <= IDLE;
      end else if (vld_p2) begin
        case (state)
          IDLE: begin
            if (!dat_line) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= (shift >> 1) | (WIDTH'(dat_line) << (WIDTH - 1));
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == LAST_BIT) state <= (PARITY != 0) ? PAR : STOP;
          end
          PAR: begin
            par_bit <= dat_line;
            state   <= STOP;
          end
          default: begin
            state <= IDLE;
            if (!parity_ok(shift, par_bit)) begin
              err      <= 1'b1;
              err_kind <= ERR_PARITY;
            end else if (!dat_line) begin
              err      <= 1'b1;
              err_kind <= ERR_STOP;
            end else begin
              word <= shift;
              done <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tappy_rx.sv
// Directed self-checking bench for tappy_rx: odd/even/no-parity instances, error classes, timeout, reset, glitch.
`timescale 1ns/1ps
module tb_tappy_rx;

  localparam int T_A = 32;
`ifdef TAPPY_RX_GLITCH_FILTER_EN
  localparam int         FILT_LAT    = 2;
  localparam logic [7:0] GLITCH_WORD = 8'hA5;
`else
  localparam int         FILT_LAT    = 0;
  // the glitch inserts an extra '1' ahead of bit 0, giving 1,1,0,1,0,0,1,0 LSB first
  localparam logic [7:0] GLITCH_WORD = 8'h4B;
`endif

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       clk_a = 1'b1, dat_a = 1'b1, clk_b = 1'b1, dat_b = 1'b1;
  logic [7:0] word_a, word_c;
  logic [8:0] word_b;
  logic       done_a, err_a, busy_a, done_b, err_b, busy_b, done_c, err_c, busy_c;
  logic [1:0] kind_a, kind_b, kind_c;

  int checks = 0;
  int fails  = 0;
  int done_n_a, err_n_a, done_n_b, err_n_b, done_n_c, err_n_c;
  int both_n = 0;

  // 16 sysclk cycles per bit at half=8 models 12.5 kHz; half=6 models 16.7 kHz (200 kHz sysclk)
  always #5 sysclk = ~sysclk;

  tappy_rx #(.WIDTH(8), .PARITY(1), .TIMEOUT(T_A)) dut_a (
    .sysclk(sysclk), .reset(reset), .clk(clk_a), .dat(dat_a), .word(word_a),
    .done(done_a), .err(err_a), .err_kind(kind_a), .busy(busy_a));

  tappy_rx #(.WIDTH(9), .PARITY(0), .TIMEOUT(32)) dut_b (
    .sysclk(sysclk), .reset(reset), .clk(clk_b), .dat(dat_b), .word(word_b),
    .done(done_b), .err(err_b), .err_kind(kind_b), .busy(busy_b));

  tappy_rx #(.WIDTH(8), .PARITY(2), .TIMEOUT(T_A)) dut_c (
    .sysclk(sysclk), .reset(reset), .clk(clk_a), .dat(dat_a), .word(word_c),
    .done(done_c), .err(err_c), .err_kind(kind_c), .busy(busy_c));

  always @(negedge sysclk) begin
    if (done_a) done_n_a++;
    if (err_a)  err_n_a++;
    if (done_b) done_n_b++;
    if (err_b)  err_n_b++;
    if (done_c) done_n_c++;
    if (err_c)  err_n_c++;
    if ((done_a && err_a) || (done_b && err_b) || (done_c && err_c)) both_n++;
  end

  task automatic clear_mon();
    done_n_a = 0; err_n_a = 0; done_n_b = 0; err_n_b = 0; done_n_c = 0; err_n_c = 0;
  endtask

  task automatic set_clk(input bit sel, input logic v);
    if (sel) clk_b = v; else clk_a = v;
  endtask

  task automatic set_dat(input bit sel, input logic v);
    if (sel) dat_b = v; else dat_a = v;
  endtask

  task automatic line_bit(input bit sel, input logic b, input int half, input bit glitch);
    @(posedge sysclk); #1; set_dat(sel, b);
    if (glitch) begin
      repeat (3) @(posedge sysclk);
      #1; set_clk(sel, 1'b0);
      @(posedge sysclk); #1; set_clk(sel, 1'b1);
      repeat (half - 4) @(posedge sysclk);
    end else begin
      repeat (half) @(posedge sysclk);
    end
    #1; set_clk(sel, 1'b0);
    repeat (half) @(posedge sysclk);
    #1; set_clk(sel, 1'b1);
  endtask

  task automatic send_frame(input bit sel, input logic [15:0] data, input int nbits, input bit has_par,
                            input logic par, input logic stop, input int half, input int glitch_bit);
    line_bit(sel, 1'b0, half, 1'b0);
    for (int i = 0; i < nbits; i++) line_bit(sel, data[i], half, (i == glitch_bit));
    if (has_par) line_bit(sel, par, half, 1'b0);
    line_bit(sel, stop, half, 1'b0);
    @(posedge sysclk); #1; set_dat(sel, 1'b1);
    repeat (10) @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    checks++; if (word_a !== 8'h00) begin fails++; $display("FAIL reset_word_a: got %h want 00", word_a); end
    checks++; if (done_a !== 1'b0)  begin fails++; $display("FAIL reset_done_a: got %b want 0", done_a); end
    checks++; if (err_a !== 1'b0)   begin fails++; $display("FAIL reset_err_a: got %b want 0", err_a); end
    checks++; if (kind_a !== 2'd0)  begin fails++; $display("FAIL reset_kind_a: got %0d want 0", kind_a); end
    checks++; if (busy_a !== 1'b0)  begin fails++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
    checks++; if (word_b !== 9'h000) begin fails++; $display("FAIL reset_word_b: got %h want 000", word_b); end
    reset = 1'b1;
    repeat (5) @(posedge sysclk);
    #1;
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b%b want 00", busy_a, busy_b); end
  endtask

  task automatic test_parity_error();
    clear_mon();
    send_frame(1'b0, 16'h00A5, 8, 1'b1, 1'b0, 1'b1, 8, -1);
    checks++; if (err_n_a !== 1)    begin fails++; $display("FAIL par_err_count: got %0d want 1", err_n_a); end
    checks++; if (kind_a !== 2'd0)  begin fails++; $display("FAIL par_err_kind: got %0d want 0", kind_a); end
    checks++; if (done_n_a !== 0)   begin fails++; $display("FAIL par_err_done: got %0d want 0", done_n_a); end
    checks++; if (word_a !== 8'h00) begin fails++; $display("FAIL par_err_word: got %h want 00", word_a); end
    checks++; if (done_n_c !== 1 || word_c !== 8'hA5) begin fails++; $display("FAIL even_par_ok: got done=%0d word=%h want 1 A5", done_n_c, word_c); end
  endtask

  task automatic test_valid();
    clear_mon();
    send_frame(1'b0, 16'h00A5, 8, 1'b1, 1'b1, 1'b1, 8, -1);
    checks++; if (done_n_a !== 1)   begin fails++; $display("FAIL valid_done: got %0d want 1", done_n_a); end
    checks++; if (word_a !== 8'hA5) begin fails++; $display("FAIL valid_word: got %h want A5", word_a); end
    checks++; if (err_n_a !== 0)    begin fails++; $display("FAIL valid_err: got %0d want 0", err_n_a); end
    checks++; if (busy_a !== 1'b0)  begin fails++; $display("FAIL valid_busy: got %b want 0", busy_a); end
    checks++; if (err_n_c !== 1 || kind_c !== 2'd0 || word_c !== 8'hA5) begin
      fails++; $display("FAIL even_par_bad: got err=%0d kind=%0d word=%h want 1 0 A5", err_n_c, kind_c, word_c); end
  endtask

  task automatic test_stop_error();
    clear_mon();
    send_frame(1'b0, 16'h003C, 8, 1'b1, 1'b1, 1'b0, 8, -1);
    checks++; if (err_n_a !== 1 || done_n_a !== 0) begin fails++; $display("FAIL stop_err_strobes: got err=%0d done=%0d want 1 0", err_n_a, done_n_a); end
    checks++; if (kind_a !== 2'd1)  begin fails++; $display("FAIL stop_err_kind: got %0d want 1", kind_a); end
    checks++; if (word_a !== 8'hA5) begin fails++; $display("FAIL stop_err_word: got %h want A5", word_a); end
    clear_mon();
    send_frame(1'b0, 16'h003C, 8, 1'b1, 1'b0, 1'b0, 8, -1);
    checks++; if (err_n_a !== 1 || kind_a !== 2'd0) begin fails++; $display("FAIL par_priority: got err=%0d kind=%0d want 1 0", err_n_a, kind_a); end
    clear_mon();
    send_frame(1'b0, 16'h003C, 8, 1'b1, 1'b1, 1'b1, 8, -1);
    checks++; if (done_n_a !== 1 || word_a !== 8'h3C) begin fails++; $display("FAIL valid_3c: got done=%0d word=%h want 1 3C", done_n_a, word_a); end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    clear_mon();
    line_bit(1'b0, 1'b0, 8, 1'b0);
    for (int i = 0; i < 3; i++) line_bit(1'b0, 1'b1, 8, 1'b0);
    @(posedge sysclk); #1; dat_a = 1'b0;
    repeat (8) @(posedge sysclk);
    #1; clk_a = 1'b0;
    checks++; if (busy_a !== 1'b1) begin fails++; $display("FAIL tmo_busy_mid: got %b want 1", busy_a); end
    // counter clears at edge 3 (2 sync + detect), reaches T at edge 3+T, err registered one edge later
    for (int k = 1; k <= T_A + 20; k++) begin
      @(posedge sysclk); #1;
      if (err_a) begin n = k; break; end
    end
    checks++; if (n !== T_A + 4 + FILT_LAT) begin fails++; $display("FAIL tmo_latency: got %0d want %0d", n, T_A + 4 + FILT_LAT); end
    checks++; if (kind_a !== 2'd2) begin fails++; $display("FAIL tmo_kind: got %0d want 2", kind_a); end
    checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL tmo_busy_after: got %b want 0", busy_a); end
    @(posedge sysclk); #1;
    checks++; if (err_a !== 1'b0) begin fails++; $display("FAIL tmo_err_width: got %b want 0", err_a); end
    checks++; if (done_n_a !== 0 || word_a !== 8'h3C) begin fails++; $display("FAIL tmo_word: got done=%0d word=%h want 0 3C", done_n_a, word_a); end
    clk_a = 1'b1; dat_a = 1'b1;
    repeat (10) @(posedge sysclk);
    clear_mon();
    send_frame(1'b0, 16'h0012, 8, 1'b1, 1'b1, 1'b1, 8, -1);
    checks++; if (done_n_a !== 1 || word_a !== 8'h12) begin fails++; $display("FAIL tmo_recover: got done=%0d word=%h want 1 12", done_n_a, word_a); end
  endtask

  task automatic test_width9();
    clear_mon();
    send_frame(1'b1, 16'h01FF, 9, 1'b0, 1'b0, 1'b1, 6, -1);
    checks++; if (done_n_b !== 1 || err_n_b !== 0) begin fails++; $display("FAIL w9_strobes: got done=%0d err=%0d want 1 0", done_n_b, err_n_b); end
    checks++; if (word_b !== 9'h1FF) begin fails++; $display("FAIL w9_word: got %h want 1FF", word_b); end
    clear_mon();
    send_frame(1'b1, 16'h0136, 9, 1'b0, 1'b0, 1'b1, 6, -1);
    checks++; if (word_b !== 9'h136) begin fails++; $display("FAIL w9_word2: got %h want 136", word_b); end
    clear_mon();
    send_frame(1'b1, 16'h00A5, 9, 1'b0, 1'b0, 1'b0, 6, -1);
    checks++; if (err_n_b !== 1 || kind_b !== 2'd1 || word_b !== 9'h136) begin
      fails++; $display("FAIL w9_stop_err: got err=%0d kind=%0d word=%h want 1 1 136", err_n_b, kind_b, word_b); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    line_bit(1'b0, 1'b0, 8, 1'b0);
    line_bit(1'b0, 1'b1, 8, 1'b0);
    line_bit(1'b0, 1'b0, 8, 1'b0);
    line_bit(1'b0, 1'b1, 8, 1'b0);
    @(posedge sysclk); #1; dat_a = 1'b0;
    repeat (3) @(posedge sysclk);
    #1; reset = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    checks++; if (word_a !== 8'h00 || busy_a !== 1'b0) begin fails++; $display("FAIL rst_mid_state: got word=%h busy=%b want 00 0", word_a, busy_a); end
    reset = 1'b1; dat_a = 1'b1;
    repeat (20) @(posedge sysclk);
    #1;
    checks++; if (done_n_a !== 0 || err_n_a !== 0 || busy_a !== 1'b0) begin
      fails++; $display("FAIL rst_mid_strobes: got done=%0d err=%0d busy=%b want 0 0 0", done_n_a, err_n_a, busy_a); end
    send_frame(1'b0, 16'h0055, 8, 1'b1, 1'b1, 1'b1, 8, -1);
    checks++; if (done_n_a !== 1 || word_a !== 8'h55) begin fails++; $display("FAIL rst_mid_recover: got done=%0d word=%h want 1 55", done_n_a, word_a); end
  endtask

  task automatic test_glitch();
    clear_mon();
    send_frame(1'b0, 16'h00A5, 8, 1'b1, 1'b1, 1'b1, 8, 0);
    checks++; if (word_a !== GLITCH_WORD) begin fails++; $display("FAIL glitch_word: got %h want %h", word_a, GLITCH_WORD); end
    checks++; if (done_n_a !== 1 || err_n_a !== 0) begin fails++; $display("FAIL glitch_strobes: got done=%0d err=%0d want 1 0", done_n_a, err_n_a); end
  endtask

  initial begin
    test_reset();
    test_parity_error();
    test_valid();
    test_stop_error();
    test_timeout();
    test_width9();
    test_reset_mid_frame();
    test_glitch();
    checks++; if (both_n !== 0) begin fails++; $display("FAIL done_err_overlap: got %0d want 0", both_n); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
